// File: rtl/mux_scan_n.sv
// Registered N:1 multiplexer with a valid/ready output stage.
// Words come from SEL (manual) or from an internal sweep pointer (scan).
module mux_scan_n #(
   parameter int BITS   = 4,
   parameter int CANAIS = 4,
   parameter int SW     = $clog2(CANAIS)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [CANAIS*BITS-1:0]   D,
   input  logic [SW-1:0]            SEL,
   input  logic                     MODO,
   input  logic                     ENABLE,
   input  logic                     PRONTO_IN,
   output logic [BITS-1:0]          MUX_OUT,
   output logic [SW-1:0]            CANAL,
   output logic                     VALIDO,
   output logic                     FIM_VARREDURA
);

   typedef enum logic {VAZIO = 1'b0, CHEIO = 1'b1} state_t;

   localparam logic [SW-1:0] LAST = SW'(CANAIS - 1);

   state_t            state_r, state_s;
   logic [BITS-1:0]   mux_r, mux_s;
   logic [SW-1:0]     canal_r, canal_s;
   logic [SW-1:0]     ptr_r, ptr_s;
   logic              mode_r, mode_s;
   logic              fim_r, fim_s;

   logic              aceite_s;
   logic              captura_s;
   logic [SW-1:0]     idx_s;
   logic [BITS-1:0]   sel_data_s;

   assign aceite_s  = (state_r == CHEIO) & PRONTO_IN;
   assign captura_s = ENABLE & ((state_r == VAZIO) | PRONTO_IN);
   assign idx_s     = MODO ? ptr_r : SEL;

   // Channel selection; an index with no matching channel yields zero data.
   always_comb begin
      sel_data_s = {BITS{1'b0}};
      for (int k = 0; k < CANAIS; k++) begin
         if (idx_s == SW'(k)) begin
            sel_data_s = D[k*BITS +: BITS];
         end else begin
            sel_data_s = sel_data_s;
         end
      end
   end

   // State and datapath registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= VAZIO;
         mux_r   <= {BITS{1'b0}};
         canal_r <= {SW{1'b0}};
         ptr_r   <= {SW{1'b0}};
         mode_r  <= 1'b0;
         fim_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         mux_r   <= mux_s;
         canal_r <= canal_s;
         ptr_r   <= ptr_s;
         mode_r  <= mode_s;
         fim_r   <= fim_s;
      end
   end

   // Next-state logic: a captured word fills the stage; acceptance without a refill empties it.
   always_comb begin
      state_s = state_r;
      case (state_r)
         VAZIO: begin
            if (captura_s) begin
               state_s = CHEIO;
            end else begin
               state_s = VAZIO;
            end
         end
         CHEIO: begin
            if (aceite_s && !ENABLE) begin
               state_s = VAZIO;
            end else begin
               state_s = CHEIO;
            end
         end
         default: state_s = VAZIO;
      endcase
   end

   // Datapath next values; the mode travels with each word so FIM follows the word, not MODO.
   always_comb begin
      mux_s   = mux_r;
      canal_s = canal_r;
      mode_s  = mode_r;
      ptr_s   = ptr_r;
      fim_s   = aceite_s & mode_r & (canal_r == LAST);
      if (captura_s) begin
         mux_s   = sel_data_s;
         canal_s = idx_s;
         mode_s  = MODO;
      end else begin
         mux_s   = mux_r;
      end
      if (!MODO) begin
         ptr_s = {SW{1'b0}};
      end else if (captura_s) begin
         ptr_s = (ptr_r == LAST) ? {SW{1'b0}} : ptr_r + SW'(1'b1);
      end else begin
         ptr_s = ptr_r;
      end
   end

   assign MUX_OUT       = mux_r;
   assign CANAL         = canal_r;
   assign VALIDO        = (state_r == CHEIO);
   assign FIM_VARREDURA = fim_r;

endmodule

// File: tb/tb_mux_scan_n.sv
// Directed bench for mux_scan_n: expected words are queued as stimulus is driven
// and checked when the DUT hands them over (VALIDO & PRONTO_IN).
module tb_mux_scan_n;

   localparam int BITS   = 4;
   localparam int CANAIS = 4;
   localparam int SW     = 2;
   localparam logic [15:0] D0 = {4'h3, 4'h2, 4'hC, 4'h5};

   logic                   clock = 1'b0;
   logic                   reset;
   logic [CANAIS*BITS-1:0] D;
   logic [SW-1:0]          SEL;
   logic                   MODO;
   logic                   ENABLE;
   logic                   PRONTO_IN;
   logic [BITS-1:0]        MUX_OUT;
   logic [SW-1:0]          CANAL;
   logic                   VALIDO;
   logic                   FIM_VARREDURA;

   typedef struct packed {
      logic [BITS-1:0] data;
      logic [SW-1:0]   canal;
      logic            fim;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   logic pending_fim = 1'b0;

   mux_scan_n #(.BITS(BITS), .CANAIS(CANAIS)) dut (
      .clock(clock), .reset(reset), .D(D), .SEL(SEL), .MODO(MODO),
      .ENABLE(ENABLE), .PRONTO_IN(PRONTO_IN), .MUX_OUT(MUX_OUT),
      .CANAL(CANAL), .VALIDO(VALIDO), .FIM_VARREDURA(FIM_VARREDURA)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [3:0] data, input logic [1:0] canal, input logic fim);
      exp_t e;
      e.data = data; e.canal = canal; e.fim = fim;
      sb.push_back(e);
   endtask

   // Scoreboard side: pop on every handshake, and track the FIM pulse it implies.
   always @(negedge clock) begin
      exp_t e;
      check("fim", {7'd0, FIM_VARREDURA}, {7'd0, pending_fim});
      pending_fim = 1'b0;
      if (reset !== 1'b1 && VALIDO === 1'b1 && PRONTO_IN === 1'b1) begin
         if (sb.size() == 0) begin
            check("sb_unexpected_word", 8'd1, 8'd0);
         end else begin
            e = sb.pop_front();
            check("sb_data", {4'd0, MUX_OUT}, {4'd0, e.data});
            check("sb_canal", {6'd0, CANAL}, {6'd0, e.canal});
            pending_fim = e.fim;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int fim_cnt;
      reset = 1'b1; ENABLE = 1'b1; MODO = 1'b1; PRONTO_IN = 1'b0; D = D0; SEL = 2'd0;

      // 1: reset for two cycles with ENABLE high, then first scan capture
      for (int i = 0; i < 2; i++) begin
         tick(1);
         check("rst_valido", {7'd0, VALIDO}, 8'd0);
         check("rst_mux", {4'd0, MUX_OUT}, 8'd0);
         check("rst_canal", {6'd0, CANAL}, 8'd0);
         check("rst_fim", {7'd0, FIM_VARREDURA}, 8'd0);
      end
      reset = 1'b0;
      push(4'h5, 2'd0, 1'b0);
      tick(1);
      check("t1_valido", {7'd0, VALIDO}, 8'd1);
      check("t1_mux", {4'd0, MUX_OUT}, 8'h05);
      check("t1_canal", {6'd0, CANAL}, 8'd0);
      ENABLE = 1'b0; PRONTO_IN = 1'b1;
      tick(1);
      check("t1_drain", {7'd0, VALIDO}, 8'd0);

      // 2: manual SEL=2 held under backpressure while D and SEL change
      MODO = 1'b0; SEL = 2'd2; ENABLE = 1'b1; PRONTO_IN = 1'b0;
      push(4'h2, 2'd2, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick(1);
         D = 16'hFFFF; SEL = 2'd1;
         check("t2_hold_valido", {7'd0, VALIDO}, 8'd1);
         check("t2_hold_mux", {4'd0, MUX_OUT}, 8'h02);
         check("t2_hold_canal", {6'd0, CANAL}, 8'd2);
      end
      ENABLE = 1'b0; PRONTO_IN = 1'b1;
      tick(1);
      check("t2_drain", {7'd0, VALIDO}, 8'd0);
      D = D0;

      // 3: continuous scan, two full sweeps with no bubbles
      MODO = 1'b1; ENABLE = 1'b1; PRONTO_IN = 1'b1;
      for (int s = 0; s < 2; s++) begin
         push(4'h5, 2'd0, 1'b0); push(4'hC, 2'd1, 1'b0);
         push(4'h2, 2'd2, 1'b0); push(4'h3, 2'd3, 1'b1);
      end
      fim_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         logic [15:0] seq;
         seq = 16'h32C5;
         tick(1);
         fim_cnt += int'(FIM_VARREDURA);
         check("t3_valido", {7'd0, VALIDO}, 8'd1);
         check("t3_mux", {4'd0, MUX_OUT}, {4'd0, seq[(i%4)*4 +: 4]});
      end
      ENABLE = 1'b0;
      tick(1);
      fim_cnt += int'(FIM_VARREDURA);
      check("t3_fim_count", 8'(fim_cnt), 8'd2);

      // 4: scan under alternating backpressure, CANAL moves only on acceptance
      ENABLE = 1'b1;
      push(4'h5, 2'd0, 1'b0); push(4'hC, 2'd1, 1'b0);
      push(4'h2, 2'd2, 1'b0); push(4'h3, 2'd3, 1'b1);
      for (int i = 0; i < 8; i++) begin
         PRONTO_IN = (i % 2 == 0) ? 1'b1 : 1'b0;
         tick(1);
         check("t4_canal", {6'd0, CANAL}, 8'(i / 2));
      end
      ENABLE = 1'b0; PRONTO_IN = 1'b1;
      tick(2);
      check("t4_drain", {7'd0, VALIDO}, 8'd0);

      // 5: manual SEL=3 gives no sweep pulse; re-entering scan restarts at channel 0
      MODO = 1'b0; SEL = 2'd3; ENABLE = 1'b1;
      push(4'h3, 2'd3, 1'b0);
      tick(1);
      ENABLE = 1'b0;
      tick(2);
      check("t5_no_fim", {7'd0, FIM_VARREDURA}, 8'd0);
      MODO = 1'b1; ENABLE = 1'b1;
      push(4'h5, 2'd0, 1'b0); push(4'hC, 2'd1, 1'b0);
      tick(1);
      check("t5_scan_canal0", {6'd0, CANAL}, 8'd0);
      check("t5_scan_mux0", {4'd0, MUX_OUT}, 8'h05);
      tick(1);
      check("t5_scan_canal1", {6'd0, CANAL}, 8'd1);
      ENABLE = 1'b0;
      tick(1);

      // 6: reset while a word is held under backpressure
      ENABLE = 1'b1; PRONTO_IN = 1'b0;
      push(4'h2, 2'd2, 1'b0);
      tick(1);
      check("t6_held", {4'd0, MUX_OUT}, 8'h02);
      reset = 1'b1; ENABLE = 1'b0;
      sb.delete();
      tick(1);
      check("t6_valido", {7'd0, VALIDO}, 8'd0);
      check("t6_mux", {4'd0, MUX_OUT}, 8'd0);
      check("t6_canal", {6'd0, CANAL}, 8'd0);
      reset = 1'b0; ENABLE = 1'b1;
      push(4'h5, 2'd0, 1'b0);
      tick(1);
      check("t6_ptr0_canal", {6'd0, CANAL}, 8'd0);
      check("t6_ptr0_mux", {4'd0, MUX_OUT}, 8'h05);
      ENABLE = 1'b0; PRONTO_IN = 1'b1;
      tick(2);
      check("t6_no_fim", {7'd0, FIM_VARREDURA}, 8'd0);
      check("sb_empty", 8'(sb.size()), 8'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
